axi_rd2noc_rsp: RTL and testbench
=================================

Name: axi_rd2noc_rsp

Overview:
- Downstream packetizer for the NoC-to-AXI master proxy read path.
- Accepts a response descriptor (pre-built header payload plus beat count) from the proxy request handler.
- Consumes AXI R-channel beats and emits one preamble-tagged response packet (header, body, tail) on the DMA NoC plane.
- Enforces flit count against AXI rlast and flags AXI error responses.

Parameters:
NOC_W, 64, DMA NoC payload width; equals AXI RDATA width, one beat per flit
LEN_W, 8, descriptor length field width (AXI ARLEN encoding: beats-1)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
desc_valid  in  1  descriptor valid
desc_ready  out  1  descriptor accept
desc_hdr  in  NOC_W  header flit payload (dest, msg type RSP_DATA_DMA/RSP_AHB_RD, reserved), pre-formed
desc_len  in  LEN_W  data beats minus 1
r_valid  in  1  AXI R valid
r_ready  out  1  AXI R ready
r_data  in  NOC_W  AXI R data
r_resp  in  2  AXI R response
r_last  in  1  AXI R last
noc_valid  out  1  output flit valid
noc_ready  in  1  output flit accept
noc_data  out  NOC_W+2  {preamble[1:0], payload}
busy  out  1  high in any state except IDLE
err  out  1  sticky per packet: SLVERR/DECERR seen or rlast mismatch; cleared at next descriptor accept

Behaviour:
- Reset (async, rstn=0): state IDLE; desc_ready=1, r_ready=0, noc_valid=0, noc_data=0, busy=0, err=0, counters 0. Reset mid-packet aborts with no tail; no further flits.
- Output stage: single register. It loads when empty or when noc_ready=1 in the same cycle. noc_valid/noc_data are held stable while noc_valid=1 and noc_ready=0.
- Preamble encoding: header 2'b10, body 2'b00, tail 2'b01. 1-flit encoding 2'b11 is never emitted; packets always have ≥2 flits.
- IDLE: desc_ready=1. On desc_valid, latch desc_hdr and remaining = desc_len (9-bit internal, beats-1), clear err, go to HDR.
- HDR: load header flit {10, hdr} into output register when it is free, then go to DATA.
- DATA: r_ready = output register free. On an R handshake, load {pre, r_data}, where pre = 01 if remaining==0, else 00. remaining decrements on each handshake.
  - r_resp ≥ 2 sets err; data is forwarded unchanged.
  - r_last with remaining>0: set err, go to PAD.
  - remaining==0 without r_last: set err, go to DRAIN.
  - remaining==0 with r_last: go to IDLE.
- PAD: r_ready=0. Emit zero-payload flits as the output frees: body 00, last one tail 01, until the count is met. Then go to IDLE.
- DRAIN: r_ready=1. Discard beats with no output; r_resp errors still set err. On r_last handshake, go to IDLE.
- IDLE with a non-empty output register: a new descriptor may be accepted. The header waits in HDR until the register frees; no flit reordering.
- Throughput: 1 flit/cycle when noc_ready=1 and r_valid=1. The header costs one cycle. Latency from R handshake to noc_valid is 1 cycle.
- r_valid in IDLE/HDR/PAD is ignored (r_ready=0).

Test Plan:
- desc_len=3, hdr=0xA5, 4 R beats 0x10..0x13 with last on 4th, noc_ready=1 → flits {10,0xA5},{00,0x10},{00,0x11},{00,0x12},{01,0x13} on consecutive cycles; err=0; busy falls after tail.
- Same packet with noc_ready toggling 1/0 each cycle → identical flit sequence; noc_data stable during stalls; r_ready low whenever output is full and not draining.
- desc_len=3, r_last on 2nd beat → flits hdr, d0, d1(00), 0(00), 0(01); err=1.
- desc_len=0, beats 0x7 (no last), 0x8 (last) → hdr, {01,0x7}; 0x8 discarded in DRAIN; err=1; returns to IDLE.
- desc_len=1, beat0 r_resp=SLVERR → both data flits forwarded, err=1; next descriptor accept clears err to 0.
- Assert rstn low during DATA after 2 flits → noc_valid=0, busy=0, desc_ready=1 immediately; a subsequent clean 1-beat packet produces hdr + tail correctly.

Source files
------------

// File: rtl/axi_rd2noc_rsp.sv
// axi_rd2noc_rsp: packs AXI R beats behind a pre-formed header into one
// preamble-tagged response packet on the DMA NoC plane.
module axi_rd2noc_rsp #(
  parameter int NOC_W = 64,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               desc_valid,
  output logic               desc_ready,
  input  logic [NOC_W-1:0]   desc_hdr,
  input  logic [LEN_W-1:0]   desc_len,
  input  logic               r_valid,
  output logic               r_ready,
  input  logic [NOC_W-1:0]   r_data,
  input  logic [1:0]         r_resp,
  input  logic               r_last,
  output logic               noc_valid,
  input  logic               noc_ready,
  output logic [NOC_W+1:0]   noc_data,
  output logic               busy,
  output logic               err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_PAD,
    ST_DRAIN
  } state_t;

  localparam logic [1:0]     PRE_HDR  = 2'b10;
  localparam logic [1:0]     PRE_BODY = 2'b00;
  localparam logic [1:0]     PRE_TAIL = 2'b01;
  localparam logic [LEN_W:0] REM_ONE  = {{LEN_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [NOC_W-1:0]    hdr_q, hdr_d;
  logic [LEN_W:0]      rem_q, rem_d;
  logic                err_q, err_d;
  logic                out_valid_q, out_valid_d;
  logic [NOC_W+1:0]    out_data_q, out_data_d;

  logic                out_free;
  logic                ld;
  logic [NOC_W+1:0]    ld_data;
  logic                rem_zero;

  assign out_free   = !out_valid_q || noc_ready;
  assign rem_zero   = (rem_q == '0);
  assign noc_valid  = out_valid_q;
  assign noc_data   = out_data_q;
  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;

  // Next-state, flit selection and output-register load.
  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    rem_d      = rem_q;
    err_d      = err_q;
    desc_ready = 1'b0;
    r_ready    = 1'b0;
    ld         = 1'b0;
    ld_data    = '0;

    case (state_q)
      ST_IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) begin
          hdr_d   = desc_hdr;
          rem_d   = {1'b0, desc_len};
          err_d   = 1'b0;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (out_free) begin
          ld      = 1'b1;
          ld_data = {PRE_HDR, hdr_q};
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        r_ready = out_free;
        if (r_valid && out_free) begin
          ld      = 1'b1;
          ld_data = {(rem_zero ? PRE_TAIL : PRE_BODY), r_data};
          rem_d   = rem_q - REM_ONE;
          if (r_resp[1]) err_d = 1'b1;
          if (rem_zero) begin
            if (r_last) begin
              state_d = ST_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (r_last) begin
            err_d   = 1'b1;
            state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        // rem_q still counts the flits owed after the early rlast.
        if (out_free) begin
          ld      = 1'b1;
          ld_data = {(rem_zero ? PRE_TAIL : PRE_BODY), {NOC_W{1'b0}}};
          rem_d   = rem_q - REM_ONE;
          if (rem_zero) state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        r_ready = 1'b1;
        if (r_valid) begin
          if (r_resp[1]) err_d = 1'b1;
          if (r_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_free) begin
      out_valid_d = ld;
      if (ld) out_data_d = ld_data;
    end
  end

  // State and output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_axi_rd2noc_rsp.sv
// Directed bench for axi_rd2noc_rsp.
module tb_axi_rd2noc_rsp;

  logic        clk = 1'b0;
  logic        rstn;
  logic        desc_valid;
  logic        desc_ready;
  logic [63:0] desc_hdr;
  logic [7:0]  desc_len;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        noc_valid;
  logic        noc_ready;
  logic [65:0] noc_data;
  logic        busy;
  logic        err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  logic        toggle_mode = 1'b0;
  logic        chk_stall   = 1'b0;
  logic        prev_stall  = 1'b0;
  logic [65:0] prev_data   = '0;

  logic [65:0] got[$];
  int unsigned got_cyc[$];
  logic [65:0] exp_q[$];

  axi_rd2noc_rsp #(.NOC_W(64), .LEN_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_hdr(desc_hdr), .desc_len(desc_len),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last),
    .noc_valid(noc_valid), .noc_ready(noc_ready), .noc_data(noc_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // noc_ready toggles just after each rising edge when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_mode) noc_ready = ~noc_ready;
    end
  end

  // Flit capture and stall-stability checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (noc_valid && noc_ready) begin
        got.push_back(noc_data);
        got_cyc.push_back(cyc);
      end
      if (chk_stall && prev_stall)
        check("stall_hold", {5'd0, noc_valid, noc_data}, {5'd0, 1'b1, prev_data});
      if (chk_stall && noc_valid && !noc_ready)
        check("rready_low_full", {71'd0, r_ready}, 72'd0);
      prev_stall = noc_valid && !noc_ready;
      prev_data  = noc_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic drive_desc(input logic [63:0] h, input logic [7:0] l);
    logic hs;
    logic ok;
    ok = 1'b0;
    desc_hdr   = h;
    desc_len   = l;
    desc_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      hs = desc_ready;
      @(posedge clk);
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    desc_valid = 1'b0;
    if (!ok) check("desc_handshake_timeout", {71'd0, ok}, 72'd1);
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [1:0] resp, input logic last);
    logic hs;
    logic ok;
    ok = 1'b0;
    r_data  = d;
    r_resp  = resp;
    r_last  = last;
    r_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      hs = r_ready;
      @(posedge clk);
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    r_valid = 1'b0;
    r_last  = 1'b0;
    if (!ok) check("r_handshake_timeout", {71'd0, ok}, 72'd1);
  endtask

  task automatic wait_flits(input int unsigned n);
    for (int i = 0; i < 100 && got.size() < n; i++) @(posedge clk);
  endtask

  task automatic check_flits(input string tag);
    check({tag, "_count"}, 72'(got.size()), 72'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_flit%0d", tag, i), {6'd0, got[i]}, {6'd0, exp_q[i]});
  endtask

  task automatic clear_logs;
    got.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    rstn       = 1'b0;
    desc_valid = 1'b0;
    desc_hdr   = '0;
    desc_len   = '0;
    r_valid    = 1'b0;
    r_data     = '0;
    r_resp     = '0;
    r_last     = 1'b0;
    noc_ready  = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_desc_ready", {71'd0, desc_ready}, 72'd1);
    check("rst_r_ready",    {71'd0, r_ready},    72'd0);
    check("rst_noc_valid",  {71'd0, noc_valid},  72'd0);
    check("rst_noc_data",   {6'd0, noc_data},    72'd0);
    check("rst_busy",       {71'd0, busy},       72'd0);
    check("rst_err",        {71'd0, err},        72'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // 1: clean 4-beat packet, full throughput.
    clear_logs();
    drive_desc(64'hA5, 8'd3);
    for (int i = 0; i < 4; i++) drive_beat(64'h10 + 64'(i), 2'b00, i == 3);
    wait_flits(5);
    exp_q = '{{2'b10, 64'hA5}, {2'b00, 64'h10}, {2'b00, 64'h11},
              {2'b00, 64'h12}, {2'b01, 64'h13}};
    check_flits("p1");
    if (got_cyc.size() == 5)
      for (int i = 1; i < 5; i++)
        check($sformatf("p1_consecutive%0d", i), 72'(got_cyc[i]), 72'(got_cyc[0] + i));
    @(negedge clk);
    check("p1_err",  {71'd0, err},  72'd0);
    check("p1_busy", {71'd0, busy}, 72'd0);

    // 2: same packet with noc_ready toggling every cycle.
    @(posedge clk);
    #1;
    clear_logs();
    chk_stall   = 1'b1;
    toggle_mode = 1'b1;
    drive_desc(64'hA5, 8'd3);
    for (int i = 0; i < 4; i++) drive_beat(64'h10 + 64'(i), 2'b00, i == 3);
    wait_flits(5);
    exp_q = '{{2'b10, 64'hA5}, {2'b00, 64'h10}, {2'b00, 64'h11},
              {2'b00, 64'h12}, {2'b01, 64'h13}};
    check_flits("p2");
    @(posedge clk);
    #1;
    toggle_mode = 1'b0;
    chk_stall   = 1'b0;
    noc_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("p2_err", {71'd0, err}, 72'd0);

    // 3: early rlast on beat 2 -> padded with zero flits.
    clear_logs();
    drive_desc(64'hB6, 8'd3);
    drive_beat(64'h20, 2'b00, 1'b0);
    drive_beat(64'h21, 2'b00, 1'b1);
    wait_flits(5);
    repeat (3) @(posedge clk);
    exp_q = '{{2'b10, 64'hB6}, {2'b00, 64'h20}, {2'b00, 64'h21},
              {2'b00, 64'h0}, {2'b01, 64'h0}};
    check_flits("p3");
    @(negedge clk);
    check("p3_err",  {71'd0, err},  72'd1);
    check("p3_busy", {71'd0, busy}, 72'd0);
    @(posedge clk);
    #1;

    // 4: missing rlast -> extra beat drained.
    clear_logs();
    drive_desc(64'hC7, 8'd0);
    drive_beat(64'h7, 2'b00, 1'b0);
    drive_beat(64'h8, 2'b00, 1'b1);
    wait_flits(2);
    repeat (3) @(posedge clk);
    exp_q = '{{2'b10, 64'hC7}, {2'b01, 64'h7}};
    check_flits("p4");
    @(negedge clk);
    check("p4_err",  {71'd0, err},  72'd1);
    check("p4_busy", {71'd0, busy}, 72'd0);
    @(posedge clk);
    #1;

    // 5: SLVERR on beat 0; data still forwarded, err cleared by next accept.
    clear_logs();
    drive_desc(64'h5A, 8'd1);
    drive_beat(64'h21, 2'b10, 1'b0);
    drive_beat(64'h22, 2'b00, 1'b1);
    wait_flits(3);
    exp_q = '{{2'b10, 64'h5A}, {2'b00, 64'h21}, {2'b01, 64'h22}};
    check_flits("p5");
    @(negedge clk);
    check("p5_err", {71'd0, err}, 72'd1);
    @(posedge clk);
    #1;
    clear_logs();
    drive_desc(64'h77, 8'd3);
    @(negedge clk);
    check("p6_err_cleared", {71'd0, err}, 72'd0);
    check("p6_busy",        {71'd0, busy}, 72'd1);

    // 6: reset mid-packet after header and one data flit.
    drive_beat(64'h30, 2'b00, 1'b0);
    wait_flits(2);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst_noc_valid",  {71'd0, noc_valid},  72'd0);
    check("mid_rst_busy",       {71'd0, busy},       72'd0);
    check("mid_rst_desc_ready", {71'd0, desc_ready}, 72'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_logs();
    drive_desc(64'h99, 8'd0);
    drive_beat(64'h44, 2'b00, 1'b1);
    wait_flits(2);
    repeat (3) @(posedge clk);
    exp_q = '{{2'b10, 64'h99}, {2'b01, 64'h44}};
    check_flits("p7");
    @(negedge clk);
    check("p7_err",  {71'd0, err},  72'd0);
    check("p7_busy", {71'd0, busy}, 72'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
